// File: rtl/oled_spi_streamer.sv
// SSD1306-class OLED driver: panel hardware reset, fixed init command list, then
// endless 1024-byte framebuffer streaming over write-only 4-wire SPI (mode 0, MSB first).
module oled_spi_streamer #(
   parameter int CLK_DIV        = 4,
   parameter int RES_CYCLES     = 25000,
   parameter int POWERUP_CYCLES = 250000,
   parameter int GAP_CYCLES     = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_to_send,
   output logic [9:0] byte_counter,
   output logic       oled_sclk,
   output logic       oled_mosi,
   output logic       oled_cs,
   output logic       oled_dc,
   output logic       oled_res,
   output logic       frame_done,
   output logic       init_done
);

   localparam int WAIT_A   = (RES_CYCLES > POWERUP_CYCLES) ? RES_CYCLES : POWERUP_CYCLES;
   localparam int WAIT_MAX = (WAIT_A > GAP_CYCLES) ? WAIT_A : GAP_CYCLES;
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
   localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [WAIT_W-1:0] RES_LAST = WAIT_W'(RES_CYCLES - 1);
   localparam logic [WAIT_W-1:0] PWR_LAST = WAIT_W'(POWERUP_CYCLES - 1);
   localparam logic [WAIT_W-1:0] GAP_LAST = WAIT_W'(GAP_CYCLES - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

   // The per-frame address window is the tail of the init list, so both share one ROM.
   localparam logic [4:0] INIT_LAST  = 5'd30;
   localparam logic [4:0] ADDR_FIRST = 5'd24;
   localparam logic [4:0] ADDR_LAST  = 5'd29;

   typedef enum logic [2:0] {S_RES_HOLD, S_PWR_WAIT, S_INIT, S_ADDR, S_DATA, S_GAP} state_t;
   typedef enum logic [1:0] {PH_LOAD0, PH_LOAD1, PH_BITS} phase_t;

   function automatic logic [7:0] cmd_rom(input logic [4:0] idx);
      case (idx)
         5'd0:  cmd_rom = 8'hAE;  5'd1:  cmd_rom = 8'hD5;  5'd2:  cmd_rom = 8'h80;
         5'd3:  cmd_rom = 8'hA8;  5'd4:  cmd_rom = 8'h3F;  5'd5:  cmd_rom = 8'hD3;
         5'd6:  cmd_rom = 8'h00;  5'd7:  cmd_rom = 8'h40;  5'd8:  cmd_rom = 8'h8D;
         5'd9:  cmd_rom = 8'h14;  5'd10: cmd_rom = 8'h20;  5'd11: cmd_rom = 8'h00;
         5'd12: cmd_rom = 8'hA1;  5'd13: cmd_rom = 8'hC8;  5'd14: cmd_rom = 8'hDA;
         5'd15: cmd_rom = 8'h12;  5'd16: cmd_rom = 8'h81;  5'd17: cmd_rom = 8'hCF;
         5'd18: cmd_rom = 8'hD9;  5'd19: cmd_rom = 8'hF1;  5'd20: cmd_rom = 8'hDB;
         5'd21: cmd_rom = 8'h40;  5'd22: cmd_rom = 8'hA4;  5'd23: cmd_rom = 8'hA6;
         5'd24: cmd_rom = 8'h21;  5'd25: cmd_rom = 8'h00;  5'd26: cmd_rom = 8'h7F;
         5'd27: cmd_rom = 8'h22;  5'd28: cmd_rom = 8'h00;  5'd29: cmd_rom = 8'h07;
         5'd30: cmd_rom = 8'hAF;
         default: cmd_rom = 8'h00;
      endcase
   endfunction

   state_t            state_q, state_d;
   phase_t            ph_q, ph_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [2:0]        bit_q, bit_d;
   logic [4:0]        rom_idx_q, rom_idx_d;
   logic [9:0]        bc_q, bc_d;
   logic [7:0]        shreg_q, shreg_d;
   logic              sclk_q, sclk_d, mosi_q, mosi_d, cs_q, cs_d, dc_q, dc_d, res_q, res_d;
   logic              frame_done_q, frame_done_d, init_done_q, init_done_d;
   logic              byte_end;
   logic [7:0]        load_byte;

   assign load_byte = (state_q == S_DATA) ? data_to_send : cmd_rom(rom_idx_q);

   always_comb begin
      state_d      = state_q;
      ph_d         = ph_q;
      wait_d       = wait_q;
      div_d        = div_q;
      bit_d        = bit_q;
      rom_idx_d    = rom_idx_q;
      bc_d         = bc_q;
      shreg_d      = shreg_q;
      sclk_d       = sclk_q;
      mosi_d       = mosi_q;
      cs_d         = cs_q;
      dc_d         = dc_q;
      res_d        = res_q;
      frame_done_d = 1'b0;
      init_done_d  = init_done_q;
      byte_end     = 1'b0;
      case (state_q)
         S_RES_HOLD: begin
            if (wait_q == RES_LAST) begin
               state_d = S_PWR_WAIT;
               wait_d  = '0;
               res_d   = 1'b1;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_PWR_WAIT: begin
            if (wait_q == PWR_LAST) begin
               state_d   = S_INIT;
               wait_d    = '0;
               cs_d      = 1'b0;
               dc_d      = 1'b0;
               rom_idx_d = '0;
               ph_d      = PH_LOAD0;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         S_GAP: begin
            if (wait_q == GAP_LAST) begin
               state_d   = S_ADDR;
               wait_d    = '0;
               cs_d      = 1'b0;
               dc_d      = 1'b0;
               rom_idx_d = ADDR_FIRST;
               ph_d      = PH_LOAD0;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         default: begin
            // Byte engine shared by INIT, ADDR and DATA; sclk_q doubles as the half-bit flag.
            case (ph_q)
               PH_LOAD0: ph_d = PH_LOAD1;
               PH_LOAD1: begin
                  shreg_d = {load_byte[6:0], 1'b0};
                  mosi_d  = load_byte[7];
                  ph_d    = PH_BITS;
                  div_d   = '0;
                  bit_d   = '0;
               end
               default: begin
                  if (div_q != DIV_LAST) begin
                     div_d = div_q + DIV_W'(1);
                  end else begin
                     div_d = '0;
                     if (!sclk_q) begin
                        sclk_d = 1'b1;
                     end else begin
                        sclk_d = 1'b0;
                        if (bit_q != 3'd7) begin
                           bit_d   = bit_q + 3'd1;
                           mosi_d  = shreg_q[7];
                           shreg_d = {shreg_q[6:0], 1'b0};
                        end else begin
                           byte_end = 1'b1;
                        end
                     end
                  end
               end
            endcase
            if (byte_end) begin
               ph_d = PH_LOAD0;
               case (state_q)
                  S_INIT: begin
                     if (rom_idx_q == INIT_LAST) begin
                        state_d     = S_ADDR;
                        init_done_d = 1'b1;
                        rom_idx_d   = ADDR_FIRST;
                     end else begin
                        rom_idx_d = rom_idx_q + 5'd1;
                     end
                  end
                  S_ADDR: begin
                     if (rom_idx_q == ADDR_LAST) begin
                        state_d = S_DATA;
                        dc_d    = 1'b1;
                        bc_d    = '0;
                     end else begin
                        rom_idx_d = rom_idx_q + 5'd1;
                     end
                  end
                  default: begin
                     if (bc_q == 10'd1023) begin
                        state_d      = S_GAP;
                        frame_done_d = 1'b1;
                        bc_d         = '0;
                        cs_d         = 1'b1;
                        mosi_d       = 1'b0;
                     end else begin
                        bc_d = bc_q + 10'd1;
                     end
                  end
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_RES_HOLD;
         ph_q         <= PH_LOAD0;
         wait_q       <= '0;
         div_q        <= '0;
         bit_q        <= '0;
         rom_idx_q    <= '0;
         bc_q         <= '0;
         sclk_q       <= 1'b0;
         mosi_q       <= 1'b0;
         cs_q         <= 1'b1;
         dc_q         <= 1'b0;
         res_q        <= 1'b0;
         frame_done_q <= 1'b0;
         init_done_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         ph_q         <= ph_d;
         wait_q       <= wait_d;
         div_q        <= div_d;
         bit_q        <= bit_d;
         rom_idx_q    <= rom_idx_d;
         bc_q         <= bc_d;
         sclk_q       <= sclk_d;
         mosi_q       <= mosi_d;
         cs_q         <= cs_d;
         dc_q         <= dc_d;
         res_q        <= res_d;
         frame_done_q <= frame_done_d;
         init_done_q  <= init_done_d;
      end
   end

   // Shift register is pure datapath: always reloaded in LOAD before it is used.
   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
   end

   assign byte_counter = bc_q;
   assign oled_sclk    = sclk_q;
   assign oled_mosi    = mosi_q;
   assign oled_cs      = cs_q;
   assign oled_dc      = dc_q;
   assign oled_res     = res_q;
   assign frame_done   = frame_done_q;
   assign init_done    = init_done_q;

endmodule
